// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_pkg                                                      |
// | Description : Shared types and constants for the VGA pattern generator:    |
// |               pattern-mode enum, colour-bar table and 640x480@60 timing.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package vga_pkg;

  // Counter / coordinate width; covers totals up to 1024 pixels or lines
  localparam int c_cnt_w = 10;

  // Default 640x480@60 timing (25.175 MHz nominal pixel clock)
  localparam int c_def_h_active = 640;
  localparam int c_def_h_fp     = 16;
  localparam int c_def_h_sync   = 96;
  localparam int c_def_h_bp     = 48;
  localparam int c_def_v_active = 480;
  localparam int c_def_v_fp     = 10;
  localparam int c_def_v_sync   = 2;
  localparam int c_def_v_bp     = 33;

  typedef enum logic [2:0] {
    MODE_SOLID    = 3'd0,
    MODE_BARS     = 3'd1,
    MODE_CHECKER  = 3'd2,
    MODE_GRADIENT = 3'd3,
    MODE_BOX      = 3'd4
  } vga_mode_e;

  // Colour-bar table as {R,G,B} on/off masks, left to right across the line
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    logic [2:0] mask;
    case (idx)
      3'd0:    mask = 3'b111; // white
      3'd1:    mask = 3'b110; // yellow
      3'd2:    mask = 3'b011; // cyan
      3'd3:    mask = 3'b010; // green
      3'd4:    mask = 3'b101; // magenta
      3'd5:    mask = 3'b100; // red
      3'd6:    mask = 3'b001; // blue
      default: mask = 3'b000; // black
    endcase
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_sync_counter                                             |
// | Description : Horizontal/vertical raster counters with region decode.      |
// |               Counters are held at (0,0) while enable is low.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = c_def_h_active,
  parameter int H_FP     = c_def_h_fp,
  parameter int H_SYNC   = c_def_h_sync,
  parameter int H_BP     = c_def_h_bp,
  parameter int V_ACTIVE = c_def_v_active,
  parameter int V_FP     = c_def_v_fp,
  parameter int V_SYNC   = c_def_v_sync,
  parameter int V_BP     = c_def_v_bp
) (
  input  logic               clk25MHz,
  input  logic               reset,
  input  logic               enable,
  output logic [c_cnt_w-1:0] h_cnt,
  output logic [c_cnt_w-1:0] v_cnt,
  output logic               active,
  output logic               hsync,
  output logic               vsync,
  output logic               first_pixel,
  output logic               last_pixel
);

  localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [c_cnt_w-1:0] c_h_last     = c_cnt_w'(c_h_total - 1);
  localparam logic [c_cnt_w-1:0] c_v_last     = c_cnt_w'(c_v_total - 1);
  localparam logic [c_cnt_w-1:0] c_h_act      = c_cnt_w'(H_ACTIVE);
  localparam logic [c_cnt_w-1:0] c_v_act      = c_cnt_w'(V_ACTIVE);
  localparam logic [c_cnt_w-1:0] c_hs_start   = c_cnt_w'(H_ACTIVE + H_FP);
  localparam logic [c_cnt_w-1:0] c_hs_end     = c_cnt_w'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [c_cnt_w-1:0] c_vs_start   = c_cnt_w'(V_ACTIVE + V_FP);
  localparam logic [c_cnt_w-1:0] c_vs_end     = c_cnt_w'(V_ACTIVE + V_FP + V_SYNC);

  logic [c_cnt_w-1:0] r_h;
  logic [c_cnt_w-1:0] r_v;

  // Raster scan: h wraps every line, v advances on the last pixel of a line
  always_ff @(posedge clk25MHz or posedge reset) begin
    if (reset) begin
      r_h <= '0;
      r_v <= '0;
    end else if (!enable) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == c_h_last) begin
      r_h <= '0;
      r_v <= (r_v == c_v_last) ? '0 : r_v + 1'b1;
    end else begin
      r_h <= r_h + 1'b1;
    end
  end

  assign h_cnt       = r_h;
  assign v_cnt       = r_v;
  assign active      = (r_h < c_h_act) && (r_v < c_v_act);
  assign hsync       = (r_h >= c_hs_start) && (r_h < c_hs_end);
  assign vsync       = (r_v >= c_vs_start) && (r_v < c_vs_end);
  assign first_pixel = (r_h == '0) && (r_v == '0);
  assign last_pixel  = (r_h == c_h_last) && (r_v == c_v_last);

endmodule
`default_nettype wire

// File: rtl/vga_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_pattern_gen                                              |
// | Description : Parametrised VGA timing and test-pattern generator with a    |
// |               one-cycle aligned output stage and an animated bouncing box. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = c_def_h_active,
  parameter int H_FP     = c_def_h_fp,
  parameter int H_SYNC   = c_def_h_sync,
  parameter int H_BP     = c_def_h_bp,
  parameter int V_ACTIVE = c_def_v_active,
  parameter int V_FP     = c_def_v_fp,
  parameter int V_SYNC   = c_def_v_sync,
  parameter int V_BP     = c_def_v_bp,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COLOR_W  = 8,
  parameter int BOX_SIZE = 32
) (
  input  logic                 clk25MHz,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           mode,
  input  logic [3*COLOR_W-1:0] fg_color,
  output logic                 VGA_HS,
  output logic                 VGA_VS,
  output logic                 VGA_BLANK_N,
  output logic [COLOR_W-1:0]   VGA_R,
  output logic [COLOR_W-1:0]   VGA_G,
  output logic [COLOR_W-1:0]   VGA_B,
  output logic [9:0]           pix_x,
  output logic [9:0]           pix_y,
  output logic                 frame_start,
  output logic [15:0]          frame_count
);

  localparam logic [c_cnt_w-1:0] c_box_x_max = c_cnt_w'(H_ACTIVE - BOX_SIZE);
  localparam logic [c_cnt_w-1:0] c_box_y_max = c_cnt_w'(V_ACTIVE - BOX_SIZE);
  localparam logic [c_cnt_w-1:0] c_box_sz    = c_cnt_w'(BOX_SIZE);
  localparam logic [c_cnt_w-1:0] c_bar_w     = c_cnt_w'(H_ACTIVE / 8);

  logic [c_cnt_w-1:0]   w_h, w_v;
  logic                 w_active, w_hsync, w_vsync, w_first, w_last;
  vga_mode_e            r_mode_s, w_mode;
  logic [3*COLOR_W-1:0] r_fg_s, w_fg, w_rgb;
  logic [c_cnt_w-1:0]   r_box_x, r_box_y;
  logic                 r_dx, r_dy;
  logic [15:0]          r_frame_count;
  logic [2:0]           w_bar;
  logic                 w_in_box;

  vga_sync_counter #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_sync (
    .clk25MHz    (clk25MHz),
    .reset       (reset),
    .enable      (enable),
    .h_cnt       (w_h),
    .v_cnt       (w_v),
    .active      (w_active),
    .hsync       (w_hsync),
    .vsync       (w_vsync),
    .first_pixel (w_first),
    .last_pixel  (w_last)
  );

  // Pixel (0,0) already uses the freshly sampled mode/colour so a whole frame
  // renders with one setting; every later pixel uses the shadow copy.
  assign w_mode = w_first ? vga_mode_e'(mode) : r_mode_s;
  assign w_fg   = w_first ? fg_color : r_fg_s;

  // Shadow mode/colour, loaded only at the top-left of the raster
  always_ff @(posedge clk25MHz or posedge reset) begin
    if (reset) begin
      r_mode_s <= MODE_SOLID;
      r_fg_s   <= '0;
    end else if (w_first) begin
      r_mode_s <= vga_mode_e'(mode);
      r_fg_s   <= fg_color;
    end
  end

  // Per-frame box motion and frame counter, advanced on the last pixel
  always_ff @(posedge clk25MHz or posedge reset) begin
    if (reset) begin
      r_box_x       <= '0;
      r_box_y       <= '0;
      r_dx          <= 1'b1;
      r_dy          <= 1'b1;
      r_frame_count <= '0;
    end else if (enable && w_last) begin
      r_frame_count <= r_frame_count + 1'b1;
      if (r_dx) begin
        if (r_box_x == c_box_x_max) begin
          r_dx    <= 1'b0;
          r_box_x <= r_box_x - 1'b1;
        end else begin
          r_box_x <= r_box_x + 1'b1;
        end
      end else begin
        if (r_box_x == '0) begin
          r_dx    <= 1'b1;
          r_box_x <= r_box_x + 1'b1;
        end else begin
          r_box_x <= r_box_x - 1'b1;
        end
      end
      if (r_dy) begin
        if (r_box_y == c_box_y_max) begin
          r_dy    <= 1'b0;
          r_box_y <= r_box_y - 1'b1;
        end else begin
          r_box_y <= r_box_y + 1'b1;
        end
      end else begin
        if (r_box_y == '0) begin
          r_dy    <= 1'b1;
          r_box_y <= r_box_y + 1'b1;
        end else begin
          r_box_y <= r_box_y - 1'b1;
        end
      end
    end
  end

  assign w_bar    = bar_rgb(3'(w_h / c_bar_w));
  assign w_in_box = (w_h >= r_box_x) && (w_h < r_box_x + c_box_sz) &&
                    (w_v >= r_box_y) && (w_v < r_box_y + c_box_sz);

  // Pattern selection for the pixel at the current counter position
  always_comb begin
    w_rgb = '0;
    case (w_mode)
      MODE_SOLID:    w_rgb = w_fg;
      MODE_BARS:     w_rgb = {{COLOR_W{w_bar[2]}}, {COLOR_W{w_bar[1]}}, {COLOR_W{w_bar[0]}}};
      MODE_CHECKER:  if (w_h[5] ^ w_v[5]) w_rgb = w_fg;
      MODE_GRADIENT: w_rgb = {COLOR_W'(w_h >> 2), COLOR_W'(w_v >> 1), COLOR_W'(r_frame_count)};
      MODE_BOX:      if (w_in_box) w_rgb = w_fg;
      default:       w_rgb = '0;
    endcase
  end

  // Output stage: everything registered from the same (h,v) for alignment
  always_ff @(posedge clk25MHz or posedge reset) begin
    if (reset) begin
      VGA_HS      <= ~HS_POL;
      VGA_VS      <= ~VS_POL;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
    end else if (!enable) begin
      VGA_HS      <= ~HS_POL;
      VGA_VS      <= ~VS_POL;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      frame_start <= 1'b0;
    end else begin
      VGA_HS      <= w_hsync ? HS_POL : ~HS_POL;
      VGA_VS      <= w_vsync ? VS_POL : ~VS_POL;
      VGA_BLANK_N <= w_active;
      VGA_R       <= w_active ? w_rgb[3*COLOR_W-1:2*COLOR_W] : '0;
      VGA_G       <= w_active ? w_rgb[2*COLOR_W-1:COLOR_W]   : '0;
      VGA_B       <= w_active ? w_rgb[COLOR_W-1:0]           : '0;
      frame_start <= w_first;
      if (w_active) begin
        pix_x <= w_h;
        pix_y <= w_v;
      end
    end
  end

  assign frame_count = r_frame_count;

endmodule
`default_nettype wire
